// File: rtl/da2_spi.sv
// rtl/da2_spi.sv - dual-channel 16-bit SPI write master for two 12-bit DACs
// Shared SYNC/sclk, one data line per channel, MSB first, all outputs registered.
module da2_spi #(
  parameter int          CLK_DIV  = 4,
  parameter int          IDLE_CYC = 2,
  parameter logic [1:0]  PD_MODE  = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] din0,
  input  logic [11:0] din1,
  output logic        cs,
  output logic        sclk,
  output logic        sdout0,
  output logic        sdout1,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HOLD_LAST = 16'(IDLE_CYC - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [4:0]  tgl_q;
  logic [15:0] shft0_q;
  logic [15:0] shft1_q;
  logic        cs_q;
  logic        sclk_q;
  logic        sdout0_q;
  logic        sdout1_q;
  logic        busy_q;
  logic        done_q;

  logic [15:0] frame0;
  logic [15:0] frame1;

  assign frame0 = {2'b00, PD_MODE, din0};
  assign frame1 = {2'b00, PD_MODE, din1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tgl_q    <= '0;
      shft0_q  <= '0;
      shft1_q  <= '0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b1;
      sdout0_q <= 1'b0;
      sdout1_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cs_q   <= 1'b1;
          sclk_q <= 1'b1;
          if (start) begin
            shft0_q  <= frame0;
            shft1_q  <= frame1;
            sdout0_q <= frame0[15];
            sdout1_q <= frame1[15];
            cs_q     <= 1'b0;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            tgl_q    <= '0;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q   <= '0;
            state_q <= SHIFT;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        SHIFT: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q <= '0;
            tgl_q <= tgl_q + 5'd1;
            // Data only changes on rising toggles, so it is stable across each DAC sample fall.
            if (sclk_q) begin
              sclk_q <= 1'b0;
            end else if (tgl_q == 5'd31) begin
              cs_q     <= 1'b1;
              sclk_q   <= 1'b1;
              sdout0_q <= 1'b0;
              sdout1_q <= 1'b0;
              state_q  <= HOLD;
            end else begin
              sclk_q   <= 1'b1;
              shft0_q  <= {shft0_q[14:0], 1'b0};
              shft1_q  <= {shft1_q[14:0], 1'b0};
              sdout0_q <= shft0_q[14];
              sdout1_q <= shft1_q[14];
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cs     = cs_q;
  assign sclk   = sclk_q;
  assign sdout0 = sdout0_q;
  assign sdout1 = sdout1_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_da2_spi.sv
// tb/tb_da2_spi.sv - directed self-checking bench for da2_spi
module tb_da2_spi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        startb = 1'b0;
  logic [11:0] din0 = '0, din1 = '0, din0b = '0, din1b = '0;
  logic        cs, sclk, sdout0, sdout1, busy, done;
  logic        csb, sclkb, sdout0b, sdout1b, busyb, doneb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  da2_spi dut (
    .clk(clk), .rst(rst), .start(start), .din0(din0), .din1(din1),
    .cs(cs), .sclk(sclk), .sdout0(sdout0), .sdout1(sdout1), .busy(busy), .done(done)
  );

  da2_spi #(.CLK_DIV(4), .IDLE_CYC(2), .PD_MODE(2'b11)) dut_pd (
    .clk(clk), .rst(rst), .start(startb), .din0(din0b), .din1(din1b),
    .cs(csb), .sclk(sclkb), .sdout0(sdout0b), .sdout1(sdout1b), .busy(busyb), .done(doneb)
  );

  int          fall_a, cslow_a, done_a, gap_run;
  bit          seen_low;
  int          gaps[$];
  logic [15:0] sh0_a, sh1_a;
  logic [15:0] w0_q[$], w1_q[$];
  int          fall_b, cslow_b;
  logic [15:0] sh0_b, sh1_b;

  always @(negedge sclk) begin
    if (!cs) begin
      sh0_a = {sh0_a[14:0], sdout0};
      sh1_a = {sh1_a[14:0], sdout1};
      fall_a++;
      if (fall_a % 16 == 0) begin
        w0_q.push_back(sh0_a);
        w1_q.push_back(sh1_a);
      end
    end
  end

  always @(negedge sclkb) begin
    if (!csb) begin
      sh0_b = {sh0_b[14:0], sdout0b};
      sh1_b = {sh1_b[14:0], sdout1b};
      fall_b++;
    end
  end

  always @(negedge clk) begin
    if (!cs) begin
      cslow_a++;
      if (seen_low && gap_run > 0) gaps.push_back(gap_run);
      gap_run = 0;
      seen_low = 1'b1;
    end else if (seen_low) begin
      gap_run++;
    end
    if (done) done_a++;
    if (!csb) cslow_b++;
  end

  task automatic clear_mon();
    fall_a = 0; cslow_a = 0; done_a = 0; gap_run = 0; seen_low = 1'b0;
    gaps.delete(); w0_q.delete(); w1_q.delete();
    sh0_a = '0; sh1_a = '0;
    fall_b = 0; cslow_b = 0; sh0_b = '0; sh1_b = '0;
  endtask

  // Drives one accepted start on the default DUT; cyc = edges from acceptance to done, -1 on timeout.
  task automatic run_frame_a(input logic [11:0] a, input logic [11:0] b, output int cyc);
    @(negedge clk); din0 = a; din1 = b; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cyc >= 400) begin cyc = -1; break; end
    end
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    #1;
    n_cmp++; if (cs !== 1'b1)     begin n_bad++; $display("FAIL reset_cs: got %b want 1", cs); end
    n_cmp++; if (sclk !== 1'b1)   begin n_bad++; $display("FAIL reset_sclk: got %b want 1", sclk); end
    n_cmp++; if (sdout0 !== 1'b0) begin n_bad++; $display("FAIL reset_sdout0: got %b want 0", sdout0); end
    n_cmp++; if (sdout1 !== 1'b0) begin n_bad++; $display("FAIL reset_sdout1: got %b want 0", sdout1); end
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)   begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int cyc;
    clear_mon();
    @(negedge clk); din0 = 12'hA5C; din1 = 12'h3F0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_cmp++; if (cs !== 1'b0)   begin n_bad++; $display("FAIL single_cs_low: got %b want 0", cs); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
    cyc = 0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cyc >= 400) begin cyc = -1; break; end
    end
    n_cmp++; if (cyc != 134)      begin n_bad++; $display("FAIL single_done_lat: got %0d want 134", cyc); end
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL single_busy_done: got %b want 0", busy); end
    n_cmp++; if (fall_a != 16)    begin n_bad++; $display("FAIL single_falls: got %0d want 16", fall_a); end
    n_cmp++; if (cslow_a != 132)  begin n_bad++; $display("FAIL single_cs_low_len: got %0d want 132", cslow_a); end
    n_cmp++; if (sh0_a !== 16'h0A5C) begin n_bad++; $display("FAIL single_word0: got %h want 0a5c", sh0_a); end
    n_cmp++; if (sh1_a !== 16'h03F0) begin n_bad++; $display("FAIL single_word1: got %h want 03f0", sh1_a); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0)   begin n_bad++; $display("FAIL single_done_pulse: got %b want 0", done); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int nd;
    int guard;
    clear_mon();
    nd = 0;
    guard = 0;
    @(negedge clk); din0 = 12'h5A5; din1 = 12'h0C3; start = 1'b1;
    while (nd < 3 && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (done) nd++;
    end
    start = 1'b0;
    n_cmp++; if (nd != 3) begin n_bad++; $display("FAIL b2b_timeout: got %0d dones want 3", nd); end
    repeat (20) @(negedge clk);
    n_cmp++; if (done_a != 3)      begin n_bad++; $display("FAIL b2b_done_count: got %0d want 3", done_a); end
    n_cmp++; if (fall_a != 48)     begin n_bad++; $display("FAIL b2b_falls: got %0d want 48", fall_a); end
    n_cmp++; if (gaps.size() != 2) begin n_bad++; $display("FAIL b2b_gap_count: got %0d want 2", gaps.size()); end
    for (int i = 0; i < gaps.size(); i++) begin
      n_cmp++; if (gaps[i] != 3) begin n_bad++; $display("FAIL b2b_gap%0d: got %0d want 3", i, gaps[i]); end
    end
    for (int i = 0; i < w0_q.size(); i++) begin
      n_cmp++; if (w0_q[i] !== 16'h05A5) begin n_bad++; $display("FAIL b2b_word0_%0d: got %h want 05a5", i, w0_q[i]); end
      n_cmp++; if (w1_q[i] !== 16'h00C3) begin n_bad++; $display("FAIL b2b_word1_%0d: got %h want 00c3", i, w1_q[i]); end
    end
  endtask

  task automatic test_busy_ignore();
    int guard;
    clear_mon();
    @(negedge clk); din0 = 12'h123; din1 = 12'h456; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    din0 = 12'hFFF; din1 = 12'h000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (60) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (!done && guard < 400) begin @(negedge clk); guard++; end
    n_cmp++; if (!done) begin n_bad++; $display("FAIL busy_timeout: got done=%b want 1", done); end
    repeat (20) @(negedge clk);
    n_cmp++; if (done_a != 1)     begin n_bad++; $display("FAIL busy_done_count: got %0d want 1", done_a); end
    n_cmp++; if (fall_a != 16)    begin n_bad++; $display("FAIL busy_falls: got %0d want 16", fall_a); end
    n_cmp++; if (cslow_a != 132)  begin n_bad++; $display("FAIL busy_cs_low_len: got %0d want 132", cslow_a); end
    n_cmp++; if (sh0_a !== 16'h0123) begin n_bad++; $display("FAIL busy_word0: got %h want 0123", sh0_a); end
    n_cmp++; if (sh1_a !== 16'h0456) begin n_bad++; $display("FAIL busy_word1: got %h want 0456", sh1_a); end
  endtask

  task automatic test_abort();
    int guard;
    int cyc;
    clear_mon();
    @(negedge clk); din0 = 12'hFFF; din1 = 12'hFFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (fall_a < 7 && guard < 400) begin @(negedge clk); guard++; end
    n_cmp++; if (fall_a != 7) begin n_bad++; $display("FAIL abort_reach7: got %0d falls want 7", fall_a); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (cs !== 1'b1)     begin n_bad++; $display("FAIL abort_cs: got %b want 1", cs); end
    n_cmp++; if (sclk !== 1'b1)   begin n_bad++; $display("FAIL abort_sclk: got %b want 1", sclk); end
    n_cmp++; if (sdout0 !== 1'b0) begin n_bad++; $display("FAIL abort_sdout0: got %b want 0", sdout0); end
    n_cmp++; if (sdout1 !== 1'b0) begin n_bad++; $display("FAIL abort_sdout1: got %b want 0", sdout1); end
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)   begin n_bad++; $display("FAIL abort_done: got %b want 0", done); end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    clear_mon();
    run_frame_a(12'h5A3, 12'hC3C, cyc);
    n_cmp++; if (cyc != 134)      begin n_bad++; $display("FAIL abort_done_lat: got %0d want 134", cyc); end
    n_cmp++; if (fall_a != 16)    begin n_bad++; $display("FAIL abort_falls: got %0d want 16", fall_a); end
    n_cmp++; if (sh0_a !== 16'h05A3) begin n_bad++; $display("FAIL abort_word0: got %h want 05a3", sh0_a); end
    n_cmp++; if (sh1_a !== 16'h0C3C) begin n_bad++; $display("FAIL abort_word1: got %h want 0c3c", sh1_a); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_pd_mode();
    int cyc;
    clear_mon();
    @(negedge clk); din0b = 12'h001; din1b = 12'hABC; startb = 1'b1;
    @(negedge clk); startb = 1'b0;
    n_cmp++; if (busyb !== 1'b1) begin n_bad++; $display("FAIL pd_busy: got %b want 1", busyb); end
    cyc = 0;
    while (!doneb) begin
      @(negedge clk);
      cyc++;
      if (cyc >= 400) begin cyc = -1; break; end
    end
    n_cmp++; if (cyc != 134)      begin n_bad++; $display("FAIL pd_done_lat: got %0d want 134", cyc); end
    n_cmp++; if (fall_b != 16)    begin n_bad++; $display("FAIL pd_falls: got %0d want 16", fall_b); end
    n_cmp++; if (cslow_b != 132)  begin n_bad++; $display("FAIL pd_cs_low_len: got %0d want 132", cslow_b); end
    n_cmp++; if (sh0_b !== 16'h3001) begin n_bad++; $display("FAIL pd_word0: got %h want 3001", sh0_b); end
    n_cmp++; if (sh1_b !== 16'h3ABC) begin n_bad++; $display("FAIL pd_word1: got %h want 3abc", sh1_b); end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_ignore();
    test_abort();
    test_pd_mode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
